// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Purpose  : Byte-serial instruction fetcher (4 bytes/word, big-endian) that
//             feeds a circular queue of {word, pc}. Define IFQ_PERF_EN to add
//             the perf_fetched / perf_stall counters.
//  Revision : 1.0
// ============================================================================
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [4:0]  imem_addr,
   input  logic [7:0]  imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [3:0]  q_count
`ifdef IFQ_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam logic [3:0]  FULL_CNT  = 4'(DEPTH);
   localparam logic [31:0] RESET_FPC = {RESET_PC[31:2], 2'b00};

   logic [31:0]      fpc_q, fpc_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [23:0]      part_q, part_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      pc_q   [DEPTH];

   logic w_pop;
   logic w_full;
   logic w_hold;
   logic w_capture;
   logic w_push;
   logic w_unused;

   assign w_unused = &{1'b0, redirect_pc[1:0]};

   assign imem_addr  = fpc_q[4:0] + {3'b000, bcnt_q};
   assign inst_valid = (cnt_q != 4'd0);
   assign inst_data  = data_q[rptr_q];
   assign inst_pc    = pc_q[rptr_q];
   assign q_count    = cnt_q;

   // The final byte of a word may only be taken when its push has room,
   // i.e. the queue is not full or the head leaves on this same edge.
   always_comb begin
      w_pop     = inst_valid & inst_ready;
      w_full    = (cnt_q == FULL_CNT);
      w_hold    = (bcnt_q == 2'd3) & w_full & ~w_pop;
      w_capture = fetch_en & ~redirect_valid & ~w_hold;
      w_push    = w_capture & (bcnt_q == 2'd3);
   end

   always_comb begin
      fpc_d  = fpc_q;
      bcnt_d = bcnt_q;
      part_d = part_q;
      if (redirect_valid) begin
         fpc_d  = {redirect_pc[31:2], 2'b00};
         bcnt_d = 2'd0;
      end else if (w_capture) begin
         if (bcnt_q == 2'd3) begin
            fpc_d  = fpc_q + 32'd4;
            bcnt_d = 2'd0;
         end else begin
            bcnt_d = bcnt_q + 2'd1;
            case (bcnt_q)
               2'd0:    part_d[23:16] = imem_rdata;
               2'd1:    part_d[15:8]  = imem_rdata;
               default: part_d[7:0]   = imem_rdata;
            endcase
         end
      end
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (redirect_valid) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = 4'd0;
      end else begin
         if (w_push) wptr_d = wptr_q + 1'b1;
         if (w_pop)  rptr_d = rptr_q + 1'b1;
         case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpc_q  <= RESET_FPC;
         bcnt_q <= 2'd0;
         part_q <= 24'd0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= 4'd0;
      end else begin
         fpc_q  <= fpc_d;
         bcnt_q <= bcnt_d;
         part_q <= part_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is cleared on reset so the head outputs read zero afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= 32'd0;
            pc_q[i]   <= 32'd0;
         end
      end else if (w_push) begin
         data_q[wptr_q] <= {part_q, imem_rdata};
         pc_q[wptr_q]   <= fpc_q;
      end
   end

`ifdef IFQ_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q <= 32'd0;
         perf_stall_q   <= 32'd0;
      end else begin
         if (w_push)
            perf_fetched_q <= perf_fetched_q + 32'd1;
         if (fetch_en & ~redirect_valid & w_hold)
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// Testbench for inst_fetch_queue: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_en = 1'b0;
   logic [4:0]  imem_addr;
   logic [7:0]  imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [3:0]  q_count;
`ifdef IFQ_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   logic [7:0] mem [32];
   int checks   = 0;
   int failures = 0;

   logic [31:0] mq [$];
   logic [31:0] m_fpc;
   int          m_nb;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr];

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .q_count       (q_count)
`ifdef IFQ_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_stall    (perf_stall)
`endif
   );

   function automatic logic [31:0] word_at(input logic [31:0] p);
      logic [4:0] a0, a1, a2, a3;
      a0 = p[4:0];
      a1 = a0 + 5'd1;
      a2 = a0 + 5'd2;
      a3 = a0 + 5'd3;
      return {mem[a0], mem[a1], mem[a2], mem[a3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      fetch_en       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
      checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", q_count); end
      checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", inst_data); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", inst_pc); end
      checks++; if (imem_addr !== RESET_PC[4:0]) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC[4:0]); end
      do_reset();
   endtask

   task automatic test_basic_fetch();
      do_reset();
      fetch_en   = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid cycle=%0d got=%b exp=0", i, inst_valid); end
         tick();
      end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", inst_valid); end
      checks++; if (inst_data !== 32'h8C220004) begin failures++; $display("FAIL basic_data got=%h exp=8c220004", inst_data); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL basic_pc got=%h exp=0", inst_pc); end
   endtask

   task automatic test_backpressure();
      do_reset();
      fetch_en   = 1'b1;
      inst_ready = 1'b0;
      repeat (40) tick();
      checks++; if (q_count !== 4'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", q_count); end
      checks++; if (imem_addr !== 5'd19) begin failures++; $display("FAIL bp_addr got=%0d exp=19", imem_addr); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%h exp=0", inst_pc); end
      checks++; if (inst_data !== word_at(32'h0)) begin failures++; $display("FAIL bp_head_data got=%h exp=%h", inst_data, word_at(32'h0)); end
      tick();
      checks++; if (imem_addr !== 5'd19) begin failures++; $display("FAIL bp_stalled_addr got=%0d exp=19", imem_addr); end
`ifdef IFQ_PERF_EN
      checks++; if (perf_stall == 32'd0) begin failures++; $display("FAIL bp_perf_stall got=%0d exp=nonzero", perf_stall); end
      checks++; if (perf_fetched !== 32'd4) begin failures++; $display("FAIL bp_perf_fetched got=%0d exp=4", perf_fetched); end
`endif
   endtask

   task automatic test_redirect_partial();
      int k;
      do_reset();
      fetch_en   = 1'b1;
      inst_ready = 1'b1;
      repeat (2) tick();
      checks++; if (imem_addr !== 5'd2) begin failures++; $display("FAIL redir_pre_addr got=%0d exp=2", imem_addr); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h13;
      tick();
      redirect_valid = 1'b0;
      checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL redir_count got=%0d exp=0", q_count); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", inst_valid); end
      checks++; if (imem_addr !== 5'd16) begin failures++; $display("FAIL redir_addr got=%0d exp=16", imem_addr); end
      k = 0;
      while (!inst_valid && k < 10) begin tick(); k++; end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL redir_timeout got=%b exp=1", inst_valid); end
      checks++; if (inst_pc !== 32'h10) begin failures++; $display("FAIL redir_word_pc got=%h exp=10", inst_pc); end
      checks++; if (inst_data !== word_at(32'h10)) begin failures++; $display("FAIL redir_word_data got=%h exp=%h", inst_data, word_at(32'h10)); end
   endtask

   task automatic test_wrap();
      int k;
      fetch_en       = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1C;
      tick();
      redirect_valid = 1'b0;
      k = 0;
      while (!inst_valid && k < 10) begin tick(); k++; end
      checks++; if (inst_pc !== 32'h1C) begin failures++; $display("FAIL wrap_pc0 got=%h exp=1c", inst_pc); end
      checks++; if (inst_data !== {mem[28], mem[29], mem[30], mem[31]}) begin failures++; $display("FAIL wrap_data0 got=%h exp=%h", inst_data, {mem[28], mem[29], mem[30], mem[31]}); end
      tick();
      k = 0;
      while (!inst_valid && k < 10) begin tick(); k++; end
      checks++; if (inst_pc !== 32'h20) begin failures++; $display("FAIL wrap_pc1 got=%h exp=20", inst_pc); end
      checks++; if (inst_data !== {mem[0], mem[1], mem[2], mem[3]}) begin failures++; $display("FAIL wrap_data1 got=%h exp=%h", inst_data, {mem[0], mem[1], mem[2], mem[3]}); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp_pc;
      do_reset();
      fetch_en   = 1'b1;
      inst_ready = 1'b0;
      repeat (20) tick();
      checks++; if (q_count !== 4'd4) begin failures++; $display("FAIL fpp_fill_count got=%0d exp=4", q_count); end
      for (int i = 0; i < 3; i++) begin
         inst_ready = 1'b1;
         tick();
         inst_ready = 1'b0;
         exp_pc = 32'(4 * (i + 1));
         checks++; if (q_count !== 4'd4) begin failures++; $display("FAIL fpp_count iter=%0d got=%0d exp=4", i, q_count); end
         checks++; if (inst_pc !== exp_pc) begin failures++; $display("FAIL fpp_head iter=%0d got=%h exp=%h", i, inst_pc, exp_pc); end
         repeat (4) tick();
      end
      fetch_en   = 1'b0;
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'(12 + 4 * i);
         checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin failures++; $display("FAIL fpp_drain_pc idx=%0d got=%h exp=%h", i, inst_pc, exp_pc); end
         checks++; if (inst_data !== word_at(exp_pc)) begin failures++; $display("FAIL fpp_drain_data idx=%0d got=%h exp=%h", i, inst_data, word_at(exp_pc)); end
         tick();
      end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fpp_drained got=%b exp=0", inst_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch_en   = 1'b1;
      inst_ready = 1'b0;
      repeat (12) tick();
      checks++; if (q_count !== 4'd3) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=3", q_count); end
      #2 reset = 1'b1;
      #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", inst_valid); end
      checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", q_count); end
      @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (imem_addr !== RESET_PC[4:0]) begin failures++; $display("FAIL rmid_addr got=%h exp=%h", imem_addr, RESET_PC[4:0]); end
      repeat (4) tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin failures++; $display("FAIL rmid_restart_pc got=%h exp=%h", inst_pc, RESET_PC); end
      checks++; if (inst_data !== word_at(RESET_PC)) begin failures++; $display("FAIL rmid_restart_data got=%h exp=%h", inst_data, word_at(RESET_PC)); end
   endtask

   // Reference: the queue holds the pcs of fully fetched words in order; a
   // word is done after four accepted bytes, and the fourth byte needs room.
   task automatic test_random();
      logic       exp_v;
      logic [4:0] exp_addr;
      logic       pop;
      logic       cap;
      do_reset();
      mq.delete();
      m_fpc = {RESET_PC[31:2], 2'b00};
      m_nb  = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         exp_v    = (mq.size() != 0);
         exp_addr = 5'(m_fpc + 32'(m_nb));
         checks++; if (inst_valid !== exp_v) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_v); end
         checks++; if (q_count !== 4'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, q_count, mq.size()); end
         checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", cyc, imem_addr, exp_addr); end
         if (exp_v) begin
            checks++; if (inst_pc !== mq[0]) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, mq[0]); end
            checks++; if (inst_data !== word_at(mq[0])) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, inst_data, word_at(mq[0])); end
         end
         fetch_en       = ($urandom_range(0, 3) != 0);
         inst_ready     = ($urandom_range(0, 2) == 0);
         redirect_valid = ($urandom_range(0, 39) == 0);
         redirect_pc    = $urandom;
         pop = exp_v && inst_ready;
         if (redirect_valid) begin
            mq.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
            m_nb  = 0;
         end else begin
            cap = fetch_en && !(m_nb == 3 && mq.size() == DEPTH && !pop);
            if (pop) void'(mq.pop_front());
            if (cap) begin
               if (m_nb == 3) begin
                  mq.push_back(m_fpc);
                  m_fpc = m_fpc + 32'd4;
                  m_nb  = 0;
               end else begin
                  m_nb++;
               end
            end
         end
         tick();
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h8C;
      mem[1] = 8'h22;
      mem[2] = 8'h00;
      mem[3] = 8'h04;
      test_reset();
      test_basic_fetch();
      test_backpressure();
      test_redirect_partial();
      test_wrap();
      test_full_push_pop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
